avalon_bus_arbiter: RTL and testbench

- Shares the single Avalon-MM memory port of the MIPS core between two requesters: instruction fetch (port I) and load/store (port D).
- Sits between the fetch/data units inside mips_cpu_bus and the external bus pins (address, read, write, writedata, byteenable, readdata, waitrequest).
- Registered grant FSM; zero-wait-state slaves give one access every 2 cycles per requester.
- Bus watchdog aborts accesses stuck on waitrequest.

---
 rtl/avalon_arb_pkg.sv | 26 ++
 rtl/avalon_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_arb_pkg.sv
// ---------------------------------------------------------------------------
// avalon_arb_pkg
// Shared types and constants for the Avalon-MM bus arbiter that multiplexes
// the instruction-fetch port and the load/store port of the MIPS core onto a
// single external memory port.
//   arb_state_t  : grant FSM states
//   req_id_t     : identifies which requester was granted last
//   BUS_ERR_DATA : read data returned to a requester whose access was
//                  aborted by the bus watchdog
// ---------------------------------------------------------------------------
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// avalon_bus_arbiter
// Shares one Avalon-MM master port between instruction fetch (I) and
// load/store (D). A registered grant FSM (IDLE -> GNT_x -> IDLE) gives a
// zero-wait-state slave one access every 2 cycles per requester. A watchdog
// aborts any access that stays stuck on waitrequest.
//
// Parameters
//   AW      : address width
//   DW      : data width (byteenable is DW/8 wide)
//   TIMEOUT : stalled grant cycles before abort, 0 disables the watchdog
//
// Ports
//   clk, reset                       : clock, synchronous active-high reset
//   i_address, i_read                : fetch request (read only)
//   i_waitrequest, i_readdata        : fetch stall / data back
//   d_address, d_read, d_write,
//   d_writedata, d_byteenable        : load/store request
//   d_waitrequest, d_readdata        : load/store stall / data back
//   address, read, write, writedata,
//   byteenable                       : external bus master outputs
//   waitrequest, readdata            : external bus slave responses
//   bus_error                        : one-cycle pulse on watchdog abort
//
// Build option
//   ARB_ROUND_ROBIN_EN : when defined, a tie in IDLE goes to the requester
//                        that was not granted last. When undefined, D always
//                        beats I.
// ---------------------------------------------------------------------------
module avalon_bus_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   i_address,
  input  logic            i_read,
  output logic            i_waitrequest,
  output logic [DW-1:0]   i_readdata,
  input  logic [AW-1:0]   d_address,
  input  logic            d_read,
  input  logic            d_write,
  input  logic [DW-1:0]   d_writedata,
  input  logic [DW/8-1:0] d_byteenable,
  output logic            d_waitrequest,
  output logic [DW-1:0]   d_readdata,
  output logic [AW-1:0]   address,
  output logic            read,
  output logic            write,
  output logic [DW-1:0]   writedata,
  output logic [DW/8-1:0] byteenable,
  input  logic            waitrequest,
  input  logic [DW-1:0]   readdata,
  output logic            bus_error
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
  // declaration stays legal when the watchdog is disabled.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t      r_state;
  arb_state_t      w_nextState;
  req_id_t         r_lastGrant;
  logic [WD_W-1:0] r_wdCount;

  logic w_reqI;
  logic w_reqD;
  logic w_grantReq;
  logic w_done;
  logic w_abort;
  logic w_pickD;

  assign w_reqI = i_read;
  assign w_reqD = d_read | d_write;

  // Tie-break when both requesters arrive in IDLE. In the fixed-priority
  // build D always wins; last grant is still tracked so both builds keep
  // identical state and reset behaviour, but it cannot change the outcome.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pickD = (r_lastGrant == REQ_I);
`else
  assign w_pickD = (r_lastGrant == REQ_I) | 1'b1;
`endif

  // Status of the currently granted requester: whether it is still asking,
  // whether the slave finished this cycle, and whether the watchdog fires.
  // The watchdog only fires on the cycle the count has reached TIMEOUT-1 and
  // the slave is still stalling, so the abort lands on grant cycle TIMEOUT.
  always_comb begin
    w_grantReq = 1'b0;
    case (r_state)
      GNT_I:   w_grantReq = w_reqI;
      GNT_D:   w_grantReq = w_reqD;
      default: w_grantReq = 1'b0;
    endcase
    w_done  = w_grantReq & ~waitrequest;
    w_abort = (TIMEOUT > 0) && w_grantReq && waitrequest && (r_wdCount == WD_LAST);
  end

  // Next-state logic. A grant always returns to IDLE after one access (or an
  // abort, or an illegal early drop of the request) so the other requester
  // gets a look-in at the next arbitration point.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_reqI && w_reqD) begin
          w_nextState = w_pickD ? GNT_D : GNT_I;
        end else if (w_reqD) begin
          w_nextState = GNT_D;
        end else if (w_reqI) begin
          w_nextState = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!w_grantReq || w_done || w_abort) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Bus and requester outputs follow the state. The requester that is not
  // granted always sees a stall and zero data. When D asserts read and write
  // together, the write is the one that reaches the bus. Reset overrides the
  // strobes immediately so an in-flight access is withdrawn in the same cycle.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    i_readdata    = '0;
    d_waitrequest = 1'b1;
    d_readdata    = '0;
    bus_error     = 1'b0;
    case (r_state)
      GNT_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = '1;
        i_waitrequest = waitrequest;
        i_readdata    = readdata;
        if (w_abort) begin
          i_waitrequest = 1'b0;
          i_readdata    = DW'(BUS_ERR_DATA);
          bus_error     = 1'b1;
        end
      end
      GNT_D: begin
        address       = d_address;
        write         = d_write;
        read          = d_read & ~d_write;
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
        d_readdata    = readdata;
        if (w_abort) begin
          d_waitrequest = 1'b0;
          d_readdata    = DW'(BUS_ERR_DATA);
          bus_error     = 1'b1;
        end
      end
      default: begin
      end
    endcase
    if (reset) begin
      read          = 1'b0;
      write         = 1'b0;
      bus_error     = 1'b0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
    end
  end

  // State, last-grant and watchdog registers. Last grant is updated whenever
  // the granted requester is released with its waitrequest low (normal
  // completion or abort), so round-robin stays fair even after a timeout.
  // The watchdog counts stalled grant cycles and clears on any state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lastGrant <= REQ_I;
      r_wdCount   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_done || w_abort) begin
        r_lastGrant <= (r_state == GNT_D) ? REQ_D : REQ_I;
      end
      if (w_nextState != r_state) begin
        r_wdCount <= '0;
      end else if ((TIMEOUT > 0) && w_grantReq && waitrequest && (r_wdCount != WD_LAST)) begin
        r_wdCount <= r_wdCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avalon_bus_arbiter
// Directed bench for avalon_bus_arbiter (TIMEOUT=4). A small slave model
// answers reads with a data pattern derived from the address and can stall
// for a programmed number of cycles or forever. Expected completions are
// queued when a request is raised and popped when the requester sees its
// waitrequest drop. Honours ARB_ROUND_ROBIN_EN for the contention ordering.
// ---------------------------------------------------------------------------
module tb_avalon_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        isWrite;
    logic        isErr;
    int          cycle;
  } exp_t;

  typedef struct {
    logic        isD;
    logic [31:0] data;
  } ord_t;

  exp_t qI[$];
  exp_t qD[$];
  ord_t qOrder[$];

  // Slave model controls
  logic stuckEn     = 1'b0;
  int   stallCycles = 0;
  int   busyCount   = 0;

  avalon_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_waitrequest(i_waitrequest),
    .i_readdata   (i_readdata),
    .d_address    (d_address),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_writedata  (d_writedata),
    .d_byteenable (d_byteenable),
    .d_waitrequest(d_waitrequest),
    .d_readdata   (d_readdata),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slaveData(input logic [31:0] a);
    case (a)
      32'd1168: slaveData = 32'h8C010064;
      32'd100:  slaveData = 32'd123;
      default:  slaveData = a ^ 32'h5A5A0000;
    endcase
  endfunction

  // Slave model: combinational read data, stall for stallCycles cycles of
  // each access (or forever while stuckEn), counting stalled cycles.
  assign readdata    = slaveData(address);
  assign waitrequest = (read | write) & (stuckEn | (busyCount < stallCycles));

  always @(posedge clk) begin
    if (!(read | write)) begin
      busyCount <= 0;
    end else if (waitrequest) begin
      busyCount <= busyCount + 1;
    end
  end

  // Global time limit so a broken DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iRd, input logic [31:0] iAddr,
                               input logic dRd, input logic dWr,
                               input logic [31:0] dAddr, input logic [31:0] dData);
    i_read      = iRd;
    i_address   = iAddr;
    d_read      = dRd;
    d_write     = dWr;
    d_address   = dAddr;
    d_writedata = dData;
  endtask

  // Runs cycles until both scoreboard queues drain, checking each completion
  // against its queued expectation (cycle number counted from the call).
  task automatic serviceBus(input string tag, input int budget);
    int   cyc;
    exp_t e;
    logic doneI;
    logic doneD;
    logic clearStuck;
    cyc = 0;
    while ((qI.size() != 0 || qD.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      doneI = 1'b0;
      doneD = 1'b0;
      clearStuck = 1'b0;
      if (i_read && !i_waitrequest && qI.size() != 0) begin
        e = qI.pop_front();
        doneI = 1'b1;
        checkOutput({tag, "/I_cycle"}, cyc, e.cycle);
        checkOutput({tag, "/I_data"}, i_readdata, e.data);
        checkOutput({tag, "/I_addr"}, address, e.addr);
        checkOutput({tag, "/I_bus_error"}, {31'b0, bus_error}, {31'b0, e.isErr});
        checkOutput({tag, "/I_other_stall"}, {31'b0, d_waitrequest}, 32'd1);
        if (e.isErr) clearStuck = 1'b1;
        else checkOutput({tag, "/I_read"}, {31'b0, read}, 32'd1);
      end
      if ((d_read || d_write) && !d_waitrequest && qD.size() != 0) begin
        e = qD.pop_front();
        doneD = 1'b1;
        checkOutput({tag, "/D_cycle"}, cyc, e.cycle);
        checkOutput({tag, "/D_addr"}, address, e.addr);
        checkOutput({tag, "/D_bus_error"}, {31'b0, bus_error}, {31'b0, e.isErr});
        checkOutput({tag, "/D_other_stall"}, {31'b0, i_waitrequest}, 32'd1);
        if (e.isWrite) begin
          checkOutput({tag, "/D_writedata"}, writedata, e.data);
          checkOutput({tag, "/D_write"}, {31'b0, write}, 32'd1);
          checkOutput({tag, "/D_read_suppressed"}, {31'b0, read}, 32'd0);
        end else begin
          checkOutput({tag, "/D_readdata"}, d_readdata, e.data);
        end
        if (e.isErr) clearStuck = 1'b1;
      end
      @(posedge clk);
      #1;
      if (doneI) i_read = 1'b0;
      if (doneD) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end
      if (clearStuck) stuckEn = 1'b0;
    end
    if (qI.size() != 0 || qD.size() != 0) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL %s_timeout observed=%0d pending expected=0 pending",
               tag, qI.size() + qD.size());
      qI.delete();
      qD.delete();
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
      stuckEn = 1'b0;
    end
  endtask

  initial begin
    ord_t o;
    reset        = 1'b1;
    d_byteenable = 4'hF;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset/read", {31'b0, read}, 32'd0);
    checkOutput("reset/write", {31'b0, write}, 32'd0);
    checkOutput("reset/i_wait", {31'b0, i_waitrequest}, 32'd1);
    checkOutput("reset/d_wait", {31'b0, d_waitrequest}, 32'd1);
    checkOutput("reset/bus_error", {31'b0, bus_error}, 32'd0);
    checkOutput("reset/address", address, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Slave stall: three stalled grant cycles, completion on grant cycle 4
    $display("[TB] slave stall");
    stallCycles = 3;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd100, 32'd0);
    qD.push_back('{32'd100, 32'd123, 1'b0, 1'b0, 5});
    serviceBus("stall", 20);
    stallCycles = 0;

    // Continuous contention for 8 cycles, last grant currently D
    $display("[TB] continuous contention");
    applyStimulus(1'b1, 32'd400, 1'b1, 1'b0, 32'd300, 32'd0);
`ifdef ARB_ROUND_ROBIN_EN
    qOrder.push_back('{1'b0, slaveData(32'd400)});
    qOrder.push_back('{1'b1, slaveData(32'd300)});
    qOrder.push_back('{1'b0, slaveData(32'd400)});
    qOrder.push_back('{1'b1, slaveData(32'd300)});
`else
    for (int k = 0; k < 4; k++) qOrder.push_back('{1'b1, slaveData(32'd300)});
`endif
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if ((c % 2) == 0 && qOrder.size() != 0) begin
        o = qOrder.pop_front();
        checkOutput("rr/winner_wait", {31'b0, o.isD ? d_waitrequest : i_waitrequest}, 32'd0);
        checkOutput("rr/loser_wait", {31'b0, o.isD ? i_waitrequest : d_waitrequest}, 32'd1);
        checkOutput("rr/data", o.isD ? d_readdata : i_readdata, o.data);
      end else begin
        checkOutput("rr/idle_i_wait", {31'b0, i_waitrequest}, 32'd1);
        checkOutput("rr/idle_d_wait", {31'b0, d_waitrequest}, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Lone fetch: bus read and completion in cycle 2
    $display("[TB] lone fetch");
    applyStimulus(1'b1, 32'd1168, 1'b0, 1'b0, 32'd0, 32'd0);
    qI.push_back('{32'd1168, 32'h8C010064, 1'b0, 1'b0, 2});
    serviceBus("fetch", 10);

    // Contention with D write (read also raised, write must win)
    $display("[TB] contention write");
    applyStimulus(1'b1, 32'd1172, 1'b1, 1'b1, 32'd200, 32'd404);
    qD.push_back('{32'd200, 32'd404, 1'b1, 1'b0, 2});
    qI.push_back('{32'd1172, slaveData(32'd1172), 1'b0, 1'b0, 4});
    serviceBus("contend", 12);

    // Watchdog: D stuck, abort on grant cycle 4, pending fetch served after
    $display("[TB] watchdog");
    stuckEn = 1'b1;
    applyStimulus(1'b1, 32'd600, 1'b1, 1'b0, 32'd500, 32'd0);
    qD.push_back('{32'd500, 32'hDEADBEEF, 1'b0, 1'b1, 5});
    qI.push_back('{32'd600, slaveData(32'd600), 1'b0, 1'b0, 7});
    serviceBus("watchdog", 20);

    // Reset in the middle of a stalled D access
    $display("[TB] reset mid-access");
    stuckEn = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd700, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_mid/granted_read", {31'b0, read}, 32'd1);
    checkOutput("rst_mid/granted_wait", {31'b0, d_waitrequest}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid/read", {31'b0, read}, 32'd0);
    checkOutput("rst_mid/write", {31'b0, write}, 32'd0);
    checkOutput("rst_mid/d_wait", {31'b0, d_waitrequest}, 32'd1);
    checkOutput("rst_mid/bus_error", {31'b0, bus_error}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid/idle_read", {31'b0, read}, 32'd0);
    checkOutput("rst_mid/idle_d_wait", {31'b0, d_waitrequest}, 32'd1);
    d_read  = 1'b0;
    stuckEn = 1'b0;

    @(negedge clk);
    @(negedge clk);
    checkOutput("end/quiet", {29'b0, read, write, bus_error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
